// File: rtl/led_fader_if.sv
// Bundle of the LED fader's enable, target levels and LED drive outputs.
// The master side drives the targets; the fader is the slave.
interface led_fader_if #(
    parameter int CH = 4
) ();
  logic          en;
  logic [CH-1:0] led_in;
  logic [CH-1:0] pwm_out;
  logic [CH-1:0] settled;
  logic          frame_pulse;

  modport master (output en, output led_in, input pwm_out, input settled, input frame_pulse);
  modport slave  (input en, input led_in, output pwm_out, output settled, output frame_pulse);
endinterface

// File: rtl/led_fader.sv
// Per-channel PWM LED driver whose duty ramps toward full-on or full-off.
// Hard on/off changes on led_in therefore become fades.
module led_fader #(
    parameter int CH       = 4,
    parameter int PWM_BITS = 8,
    parameter int STEP     = 16,
    parameter int FADE_DIV = 4096
) (
  input logic         clk,
  input logic         rst,
  led_fader_if.slave  bus
);
  localparam int MAX    = 2 ** PWM_BITS - 1;
  localparam int FDIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [PWM_BITS-1:0] MAX_V     = PWM_BITS'(MAX);
  localparam logic [PWM_BITS:0]   MAX_WIDE  = (PWM_BITS + 1)'(MAX);
  localparam logic [PWM_BITS:0]   STEP_WIDE = (PWM_BITS + 1)'(STEP);
  localparam logic [FDIV_W-1:0]   FDIV_LAST = FDIV_W'(FADE_DIV - 1);

  typedef enum logic [1:0] {ST_OFF, ST_RISE, ST_ON, ST_FALL} state_t;

  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [FDIV_W-1:0]   fdiv_reg;
  logic                frame_pulse_reg;
  logic                step_tick;

  assign step_tick = bus.en && (fdiv_reg == FDIV_LAST);

  // The PWM period is MAX slots so that duty == MAX is a constant high.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_reg     <= '0;
      fdiv_reg        <= '0;
      frame_pulse_reg <= 1'b0;
    end else begin
      pwm_cnt_reg     <= (pwm_cnt_reg == MAX_V - 1'b1) ? '0 : pwm_cnt_reg + 1'b1;
      frame_pulse_reg <= (pwm_cnt_reg == MAX_V - 1'b1);
      if (bus.en) begin
        fdiv_reg <= (fdiv_reg == FDIV_LAST) ? '0 : fdiv_reg + 1'b1;
      end
    end
  end

  assign bus.frame_pulse = frame_pulse_reg;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [PWM_BITS-1:0] duty_reg;
      logic [PWM_BITS-1:0] duty_next;
      logic [PWM_BITS:0]   duty_sum;
      state_t              state_reg;
      state_t              state_next;
      logic                pwm_bit_reg;
      logic                settled_bit_reg;
      logic                settled_comb;

      // State register together with the duty it tracks.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg       <= ST_OFF;
          duty_reg        <= '0;
          pwm_bit_reg     <= 1'b0;
          settled_bit_reg <= 1'b1;
        end else begin
          state_reg       <= state_next;
          duty_reg        <= duty_next;
          pwm_bit_reg     <= (pwm_cnt_reg < duty_reg);
          settled_bit_reg <= settled_comb;
        end
      end

      // Saturating step; direction comes from led_in, not from the state.
      always_comb begin
        duty_sum   = {1'b0, duty_reg} + STEP_WIDE;
        duty_next  = duty_reg;
        state_next = state_reg;
        if (step_tick) begin
          if (bus.led_in[gi]) begin
            duty_next = (duty_sum > MAX_WIDE) ? MAX_V : duty_sum[PWM_BITS-1:0];
          end else begin
            duty_next = ({1'b0, duty_reg} >= STEP_WIDE) ?
                        duty_reg - STEP_WIDE[PWM_BITS-1:0] : '0;
          end
        end
        if (bus.led_in[gi]) begin
          state_next = (duty_next == MAX_V) ? ST_ON : ST_RISE;
        end else begin
          state_next = (duty_next == '0) ? ST_OFF : ST_FALL;
        end
      end

      always_comb begin
        settled_comb = (state_reg == ST_ON) || (state_reg == ST_OFF);
      end

      assign bus.pwm_out[gi] = pwm_bit_reg;
      assign bus.settled[gi] = settled_bit_reg;
    end
  endgenerate
endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader: a behavioural model predicts every cycle's
// outputs into a queue and an independent monitor pops and compares them.
module tb_led_fader;
  localparam int CH       = 4;
  localparam int PWM_BITS = 8;
  localparam int STEP     = 64;
  localparam int FADE_DIV = 4;
  localparam int MAX      = 2 ** PWM_BITS - 1;

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic [CH-1:0] settled;
    logic          frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  exp_t exp_q[$];

  int            m_cnt;
  int            m_fdiv;
  int            m_duty[CH];
  logic [CH-1:0] m_stable;

  led_fader_if #(.CH(CH)) bus ();

  led_fader #(
    .CH(CH), .PWM_BITS(PWM_BITS), .STEP(STEP), .FADE_DIV(FADE_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    exp_t e;
    bit   tick;
    if (rst) begin
      e.pwm = '0; e.settled = '1; e.frame = 1'b0;
      m_cnt = 0; m_fdiv = 0; m_stable = '1;
      for (int i = 0; i < CH; i++) m_duty[i] = 0;
    end else begin
      for (int i = 0; i < CH; i++) e.pwm[i] = (m_cnt < m_duty[i]);
      e.frame   = (m_cnt == MAX - 1);
      e.settled = m_stable;
      tick   = bus.en && (m_fdiv == FADE_DIV - 1);
      m_cnt  = (m_cnt + 1) % MAX;
      if (bus.en) m_fdiv = (m_fdiv + 1) % FADE_DIV;
      for (int i = 0; i < CH; i++) begin
        if (tick) begin
          if (bus.led_in[i]) m_duty[i] = (m_duty[i] + STEP > MAX) ? MAX : m_duty[i] + STEP;
          else               m_duty[i] = (m_duty[i] - STEP < 0) ? 0 : m_duty[i] - STEP;
        end
        m_stable[i] = bus.led_in[i] ? (m_duty[i] == MAX) : (m_duty[i] == 0);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #2;
    end
  endtask

  // Monitor: the DUT presents a new output word every cycle.
  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.pwm = bus.pwm_out; a.settled = bus.settled; a.frame = bus.frame_pulse;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t pwm=%b/%b settled=%b/%b frame=%b/%b (actual/required)",
                 $time, a.pwm, e.pwm, a.settled, e.settled, a.frame, e.frame);
      end
    end
  end

  initial begin
    bus.en = 1'b1;
    bus.led_in = '0;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(600);
    $display("txn idle: 600 cycles led_in=0");

    bus.led_in[0] = 1'b1;
    cycles(40);
    $display("txn ramp_up: ch0 to full, duty0=%0d", m_duty[0]);

    bus.led_in[0] = 1'b0;
    cycles(40);
    bus.led_in[0] = 1'b1;
    while (m_duty[0] < 128) cycles(1);
    bus.led_in[0] = 1'b0;
    cycles(30);
    $display("txn reversal: ch0 reversed at 128, duty0=%0d", m_duty[0]);

    bus.led_in[0] = 1'b1;
    while (m_duty[0] < 192) cycles(1);
    bus.en = 1'b0;
    cycles(100);
    bus.en = 1'b1;
    cycles(40);
    $display("txn freeze: en low 100 cycles at 192, duty0=%0d", m_duty[0]);

    while (m_fdiv != FADE_DIV - 1) cycles(1);
    bus.led_in[1] = 1'b1;
    cycles(1);
    cycles(20);
    $display("txn tick_toggle: ch1 raised on step cycle, duty1=%0d", m_duty[1]);

    bus.led_in = '0;
    cycles(40);
    bus.led_in = '1;
    cycles(40);
    bus.led_in = '0;
    cycles(40);
    $display("txn all_channels: simultaneous ramps");

    bus.led_in = '1;
    cycles(40);
    bus.led_in = '0;
    while (m_duty[0] > 128) cycles(1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(300);
    $display("txn reset_mid_fall: duty0=%0d", m_duty[0]);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) bus.led_in = CH'($urandom);
      bus.en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 499) == 0);
      cycles(1);
    end
    rst = 1'b0;
    bus.en = 1'b1;
    bus.led_in = CH'($urandom);
    cycles(300);
    $display("txn random: 3300 cycles");

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream consumer of the running-lights sequencer: takes its per-LED on/off levels and drives the physical LED pins.
- Each output is a PWM signal whose duty ramps smoothly toward full-on or full-off, so hard toggles become fades.
- Contains a free-running PWM counter, an internal fade-rate divider, and one saturating duty register plus a 4-state FSM per channel.

Parameters:
- CH, 4: number of LED channels.
- PWM_BITS, 8: duty/counter width; MAX = 2^PWM_BITS-1 (255).
- STEP, 16: duty increment/decrement per fade step; legal range 1..MAX.
- FADE_DIV, 4096: clocks between fade steps; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  fade enable; low freezes all duties and the fade divider, PWM keeps running.
- led_in  in  CH  target level per channel (1 = fade on, 0 = fade off), e.g. {led4,led3,led2,led1}.
- pwm_out  out  CH  registered PWM drive to LED pins.
- settled  out  CH  1 when channel duty equals its target extreme (0 or MAX) and matches led_in.
- frame_pulse  out  1  one-cycle pulse at end of each PWM period.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset (rst=1 at posedge):
  - pwm_cnt, fdiv and all duty registers clear to 0.
  - All channel FSMs go to OFF.
  - pwm_out=0, settled=all 1, frame_pulse=0.
  - rst asserted mid-fade aborts immediately; no partial step is applied.
- PWM counter:
  - pwm_cnt counts 0..MAX-1, then wraps to 0. Period is MAX clocks (255), so full duty gives a constant 1.
- PWM output:
  - pwm_out[i] <= (pwm_cnt < duty[i]), registered, so one-cycle latency from counter to pin.
  - duty=0 gives a constant 0; duty=MAX gives a constant 1.
  - A duty change takes effect on the next compare cycle; no glitch suppression or period alignment is required.
- frame_pulse <= (pwm_cnt == MAX-1), registered, aligned with the pwm_out sample of the last slot.
- Fade divider:
  - When en=1, fdiv counts 0..FADE_DIV-1 and wraps.
  - step_tick is asserted internally for the single cycle where fdiv == FADE_DIV-1 and en=1.
  - When en=0, fdiv holds and no step_tick occurs.
- Duty update, per channel, only on step_tick:
  - led_in[i]=1: duty <= min(duty+STEP, MAX). Compute in PWM_BITS+1 bits, then saturate.
  - led_in[i]=0: duty <= max(duty-STEP, 0). Compare before subtracting; never wrap.
  - Direction is taken from led_in sampled in the step_tick cycle, not from the FSM state.
- Channel FSM, next state computed every cycle from led_in[i] and duty_next:
  - OFF: duty_next==0 and led_in=0.
  - ON: duty_next==MAX and led_in=1.
  - RISE: led_in=1 and duty_next<MAX.
  - FALL: led_in=0 and duty_next>0.
  - Resulting transitions:
    - OFF->RISE when led_in rises.
    - RISE->ON on the step that reaches MAX.
    - RISE->FALL when led_in falls mid-ramp; ramping reverses from the current duty with no jump.
    - ON->FALL when led_in falls.
    - FALL->OFF on the step that reaches 0.
    - FALL->RISE when led_in rises mid-ramp.
  - settled[i] = registered (state==ON or state==OFF); 1 cycle after the state update.
- Boundary cases:
  - A led_in toggle in the same cycle as step_tick steps in the new direction.
  - A led_in pulse shorter than FADE_DIV with no step_tick in between changes state but not duty; settled drops and then returns.
  - STEP=MAX reduces the fade to a single-step snap.
  - Channels are fully independent; all four may ramp simultaneously.

Test Plan:
- Reset/idle: FADE_DIV=4, STEP=64, rst 2 cycles, led_in=0 for 600 cycles -> pwm_out=0 throughout, settled=4'b1111, frame_pulse every 255 cycles.
- Ramp up, saturation: led_in[0] 0->1 -> duty0 takes 64, 128, 192, 255 on successive step_ticks (every 4 clocks). settled[0] is 0 until 255, then 1. pwm_out[0] is high for 64, 128, 192 of 255 slots, then constant 1.
- Reversal mid-ramp: after duty0=128, drop led_in[0] -> next steps give 64, 0. FSM goes RISE->FALL->OFF; duty never underflows and never exceeds 128.
- Enable freeze: en=0 at duty=192 for 100 cycles -> duty and fdiv unchanged, PWM continues at 192/255. en=1 -> fade resumes in the original cadence.
- Simultaneous events: toggle led_in[1] exactly on a step_tick cycle -> step applied in the new direction. Toggle all four channels at once -> identical independent ramps.
- Reset mid-operation: rst during FALL at duty=128 -> next cycle duty=0, pwm_out=0, state OFF, fdiv=0.
